h264_bitstream_sched: RTL and testbench
=======================================

// Module: h264_bitstream_sched
// PURPOSE
//  Shares the single h264tobytes bit packer between N codeword producers
//  (e.g. SPS/PPS writer, slice/MB header writer, CAVLC residual writer).
//  Round-robin arbitration; the grant stays locked until the holder's LAST word.
//  Tracks the bit position mod 8 and, on end-of-stream, emits the RBSP stop bit
//  and zero padding so the packer ends byte-aligned. Sits between producers and h264tobytes.
// PARAMETERS
//  N_REQ   3   number of requesters (>=2)
//  VE_W    25  codeword value width
//  VL_W    5   codeword length width; legal VL 1..MAX_VL (25)
// PORTS
//  CLK        in   1           clock, all logic on posedge
//  RST        in   1           synchronous reset, active high
//  REQ_VALID  in   N_REQ       requester i has a word
//  REQ_VE     in   N_REQ*VE_W  codeword values, req i at [i*VE_W +: VE_W], right-aligned
//  REQ_VL     in   N_REQ*VL_W  codeword lengths
//  REQ_LAST   in   N_REQ       word is the last of requester's burst
//  REQ_READY  out  N_REQ       word accepted this cycle
//  EOS_REQ    in   1           end of stream; held high until EOS_DONE
//  EOS_DONE   out  1           one-cycle pulse: stop bit + pad accepted by packer
//  VALID      out  1           to packer: VE/VL valid
//  VE         out  VE_W        to packer
//  VL         out  VL_W        to packer
//  READY      in   1           from packer: word accepted when VALID&&READY
//  GNT        out  N_REQ       one-hot current grant (debug/monitor)
//  ERR        out  1           sticky: a word with VL>MAX_VL was seen
// BEHAVIOUR
//  Reset: VALID=0 VE=0 VL=0 REQ_READY=0 GNT=0 EOS_DONE=0 ERR=0; rr ptr=0, bitpos=0, state IDLE.
//  States: IDLE, GRANT, STOP, PAD, FIN.
//  IDLE: any REQ_VALID -> pick first valid at/after rr ptr, register GNT, go GRANT
//   (1-cycle arbitration latency). Else if EOS_REQ -> STOP. Requests beat EOS on same cycle.
//  GRANT: combinational pass-through of granted req: VALID=REQ_VALID[g], VE/VL from g,
//   REQ_READY[g]=READY, other REQ_READY=0. On handshake: bitpos+=VL mod 8.
//   Handshake with REQ_LAST[g]=1 -> rr ptr=g+1 (wraps N_REQ-1 -> 0), GNT=0, IDLE.
//   Requester may drop REQ_VALID mid-burst; grant stays locked.
//  VL=0 word: REQ_READY[g]=1, VALID=0 (consumed, not forwarded), bitpos unchanged; LAST still honoured.
//  VL>MAX_VL: forwarded unchanged, ERR set (cleared only by RST).
//  STOP: drive VE=1 VL=1 VALID=1; on READY: p=(bitpos+1) mod 8; p!=0 -> PAD else FIN.
//  PAD: drive VE=0 VL=8-p VALID=1; on READY -> FIN.
//  FIN: EOS_DONE=1 one cycle, bitpos=0, -> IDLE. REQ_READY all 0 during STOP/PAD/FIN.
//  VALID/VE/VL stable while VALID&&!READY (AXI-style; packer may stall any cycle).
//  VE/VL driven 0 whenever VALID=0.
//  RST mid-burst or mid-EOS: immediate return to reset state; no partial word or pad owed.
// STRUCTURE
//  h264_bs_pkg: state enum bs_state_t, VE_W/VL_W/MAX_VL constants.
//  Sub-module h264_rr_arbiter (N_REQ, req vector + ptr -> one-hot grant, any).
//  Top: FSM, output mux, bitpos counter (3 bits), rr ptr register.
// TESTING
//  1 Single req0 burst VE=56789/VL=25, then VE=5/VL=3 LAST, READY=1 ->
//    GNT=001 one cycle after REQ_VALID, two VALID beats, bitpos=4, IDLE.
//  2 req0,req1,req2 all valid, 1-word LAST bursts, ptr=0 -> order 0,1,2,
//    then req0+req2 again -> 0 then 2 (ptr wrap).
//  3 EOS after 12 bits sent (bitpos=4) -> STOP VE=1/VL=1, PAD VE=0/VL=3, EOS_DONE pulse, bitpos=0.
//  4 EOS with bitpos=7 -> stop bit only, no PAD beat, EOS_DONE.
//  5 READY low 3 cycles during GRANT and PAD -> VE/VL/VALID held; no REQ_READY; no double count.
//  6 RST mid-burst; VL=0 word (consumed, VALID=0); VL=31 word -> ERR=1 sticky.

Source files
------------

// File: rtl/h264_bs_pkg.sv
// Shared types and constants for the H.264 bitstream scheduler.
package h264_bs_pkg;

    localparam int BS_VE_W   = 25;
    localparam int BS_VL_W   = 5;
    localparam int BS_MAX_VL = 25;

    typedef enum logic [2:0] {
        BS_IDLE  = 3'd0,
        BS_GRANT = 3'd1,
        BS_STOP  = 3'd2,
        BS_PAD   = 3'd3,
        BS_FIN   = 3'd4
    } bs_state_t;

endpackage

// File: rtl/h264_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, as one-hot plus index.
module h264_rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    gnt_idx,
    output logic             any
);

    // scan requesters in rotated order starting at ptr
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = {N_REQ{1'b0}};
        gnt_idx = {PW{1'b0}};
        any     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                any      = 1'b1;
            end else begin
                any      = any;
            end
        end
    end

endmodule

// File: rtl/h264_bitstream_sched.sv
// Shares one h264tobytes packer among N_REQ producers; appends the RBSP stop bit
// and zero padding on end-of-stream so the packer finishes byte-aligned.
module h264_bitstream_sched
    import h264_bs_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int VE_W  = BS_VE_W,
    parameter int VL_W  = BS_VL_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ_VALID,
    input  logic [N_REQ*VE_W-1:0] REQ_VE,
    input  logic [N_REQ*VL_W-1:0] REQ_VL,
    input  logic [N_REQ-1:0]      REQ_LAST,
    output logic [N_REQ-1:0]      REQ_READY,
    input  logic                  EOS_REQ,
    output logic                  EOS_DONE,
    output logic                  VALID,
    output logic [VE_W-1:0]       VE,
    output logic [VL_W-1:0]       VL,
    input  logic                  READY,
    output logic [N_REQ-1:0]      GNT,
    output logic                  ERR
);

    localparam int PW = $clog2(N_REQ);

    bs_state_t        state_r, state_nx_s;
    logic [N_REQ-1:0] gnt_r;
    logic [PW-1:0]    gidx_r;
    logic [PW-1:0]    ptr_r;
    logic [2:0]       bitpos_r;
    logic             err_r;

    logic [N_REQ-1:0] arb_gnt_s;
    logic [PW-1:0]    arb_idx_s;
    logic             arb_any_s;

    logic [VE_W-1:0]  g_ve_s;
    logic [VL_W-1:0]  g_vl_s;
    logic             g_valid_s;
    logic             g_last_s;
    logic             accept_s;

    h264_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req     (REQ_VALID),
        .ptr     (ptr_r),
        .gnt     (arb_gnt_s),
        .gnt_idx (arb_idx_s),
        .any     (arb_any_s)
    );

    // fields of the currently granted requester
    always_comb begin
        g_ve_s    = REQ_VE[int'(gidx_r)*VE_W +: VE_W];
        g_vl_s    = REQ_VL[int'(gidx_r)*VL_W +: VL_W];
        g_valid_s = REQ_VALID[gidx_r];
        g_last_s  = REQ_LAST[gidx_r];
    end

    // next state and packer/requester handshake outputs
    always_comb begin
        state_nx_s = state_r;
        VALID      = 1'b0;
        VE         = {VE_W{1'b0}};
        VL         = {VL_W{1'b0}};
        REQ_READY  = {N_REQ{1'b0}};
        accept_s   = 1'b0;
        case (state_r)
            BS_IDLE: begin
                if (arb_any_s) begin
                    state_nx_s = BS_GRANT;
                end else if (EOS_REQ) begin
                    state_nx_s = BS_STOP;
                end else begin
                    state_nx_s = BS_IDLE;
                end
            end
            BS_GRANT: begin
                // zero-length words are swallowed here and never reach the packer
                if (g_vl_s != {VL_W{1'b0}}) begin
                    VALID             = g_valid_s;
                    VE                = g_valid_s ? g_ve_s : {VE_W{1'b0}};
                    VL                = g_valid_s ? g_vl_s : {VL_W{1'b0}};
                    REQ_READY[gidx_r] = READY;
                    accept_s          = g_valid_s && READY;
                end else begin
                    REQ_READY[gidx_r] = 1'b1;
                    accept_s          = g_valid_s;
                end
                if (accept_s && g_last_s) begin
                    state_nx_s = BS_IDLE;
                end else begin
                    state_nx_s = BS_GRANT;
                end
            end
            BS_STOP: begin
                VALID = 1'b1;
                VE    = {{(VE_W-1){1'b0}}, 1'b1};
                VL    = {{(VL_W-1){1'b0}}, 1'b1};
                if (READY) begin
                    state_nx_s = (bitpos_r == 3'd7) ? BS_FIN : BS_PAD;
                end else begin
                    state_nx_s = BS_STOP;
                end
            end
            BS_PAD: begin
                // bitpos_r already includes the stop bit here
                VALID = 1'b1;
                VL    = VL_W'(4'd8) - VL_W'(bitpos_r);
                if (READY) begin
                    state_nx_s = BS_FIN;
                end else begin
                    state_nx_s = BS_PAD;
                end
            end
            BS_FIN: begin
                state_nx_s = BS_IDLE;
            end
            default: begin
                state_nx_s = BS_IDLE;
            end
        endcase
    end

    // state, grant, round-robin pointer, bit position and error flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= BS_IDLE;
            gnt_r    <= {N_REQ{1'b0}};
            gidx_r   <= {PW{1'b0}};
            ptr_r    <= {PW{1'b0}};
            bitpos_r <= 3'd0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                BS_IDLE: begin
                    if (arb_any_s) begin
                        gnt_r  <= arb_gnt_s;
                        gidx_r <= arb_idx_s;
                    end
                end
                BS_GRANT: begin
                    if (accept_s) begin
                        bitpos_r <= bitpos_r + g_vl_s[2:0];
                        if (g_vl_s > VL_W'(BS_MAX_VL)) begin
                            err_r <= 1'b1;
                        end
                        if (g_last_s) begin
                            gnt_r <= {N_REQ{1'b0}};
                            ptr_r <= (gidx_r == PW'(N_REQ-1)) ? {PW{1'b0}} : gidx_r + PW'(1);
                        end
                    end
                end
                BS_STOP: begin
                    if (READY) begin
                        bitpos_r <= bitpos_r + 3'd1;
                    end
                end
                BS_FIN: begin
                    bitpos_r <= 3'd0;
                end
                default: begin
                    bitpos_r <= bitpos_r;
                end
            endcase
        end
    end

    assign EOS_DONE = (state_r == BS_FIN);
    assign GNT      = gnt_r;
    assign ERR      = err_r;

endmodule

// File: tb/tb_h264_bitstream_sched.sv
// Scoreboard bench for h264_bitstream_sched: directed producer/EOS traffic, packer beats checked by a monitor.
module tb_h264_bitstream_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  REQ_VALID = 3'b000;
    logic [74:0] REQ_VE = 75'd0;
    logic [14:0] REQ_VL = 15'd0;
    logic [2:0]  REQ_LAST = 3'b000;
    logic [2:0]  REQ_READY;
    logic        EOS_REQ = 1'b0;
    logic        EOS_DONE;
    logic        VALID;
    logic [24:0] VE;
    logic [4:0]  VL;
    logic        READY = 1'b1;
    logic [2:0]  GNT;
    logic        ERR;

    typedef struct {
        logic [24:0] ve;
        logic [4:0]  vl;
        logic [2:0]  gnt;
    } beat_t;

    beat_t exp_q[$];
    beat_t b;
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    mbit   = 0;
    logic  v;

    h264_bitstream_sched dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_VE(REQ_VE), .REQ_VL(REQ_VL),
        .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .EOS_REQ(EOS_REQ), .EOS_DONE(EOS_DONE),
        .VALID(VALID), .VE(VE), .VL(VL), .READY(READY), .GNT(GNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_word(input logic [24:0] ve, input logic [4:0] vl, input logic [2:0] g);
        if (vl != 5'd0) begin
            exp_q.push_back('{ve, vl, g});
            mbit = (mbit + int'(vl)) % 8;
        end
    endtask

    task automatic put(input int i, input logic [24:0] ve, input logic [4:0] vl,
                       input logic last, output logic vout);
        int cnt;
        bit hs;
        REQ_VE[i*25 +: 25] = ve;
        REQ_VL[i*5 +: 5]   = vl;
        REQ_LAST[i]        = last;
        REQ_VALID[i]       = 1'b1;
        hs   = 1'b0;
        cnt  = 0;
        vout = 1'b0;
        while (!hs && cnt < 40) begin
            @(negedge CLK);
            cnt++;
            if (REQ_READY[i]) begin
                hs   = 1'b1;
                vout = VALID;
            end
        end
        if (!hs) begin
            n_cmp++;
            n_fail++;
            $display("FAIL put_timeout: req%0d word not accepted within 40 cycles", i);
        end
        @(posedge CLK);
        #1;
        REQ_VALID[i] = 1'b0;
    endtask

    task automatic eos();
        int cnt;
        bit seen;
        int p;
        p = (mbit + 1) % 8;
        exp_q.push_back('{25'd1, 5'd1, 3'b000});
        if (p != 0) exp_q.push_back('{25'd0, 5'(8 - p), 3'b000});
        mbit    = 0;
        EOS_REQ = 1'b1;
        seen    = 1'b0;
        cnt     = 0;
        while (!seen && cnt < 60) begin
            @(negedge CLK);
            cnt++;
            if (EOS_DONE) seen = 1'b1;
        end
        chk("eos_done_seen", {31'd0, seen}, 32'd1);
        EOS_REQ = 1'b0;
        @(negedge CLK);
        chk("eos_done_one_cycle", {31'd0, EOS_DONE}, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic hold_chk(input string nm, input logic [24:0] ve, input logic [4:0] vl);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk({nm, "_valid"}, {31'd0, VALID}, 32'd1);
            chk({nm, "_ve"}, {7'd0, VE}, {7'd0, ve});
            chk({nm, "_vl"}, {27'd0, VL}, {27'd0, vl});
            chk({nm, "_req_ready"}, {29'd0, REQ_READY}, 32'd0);
        end
    endtask

    // scoreboard monitor: every packer handshake pops one expected beat
    always @(negedge CLK) begin
        if (!RST && VALID && READY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got VE=%0h VL=%0d with no beat expected", VE, VL);
            end else begin
                b = exp_q.pop_front();
                chk("beat_ve", {7'd0, VE}, {7'd0, b.ve});
                chk("beat_vl", {27'd0, VL}, {27'd0, b.vl});
                chk("beat_gnt", {29'd0, GNT}, {29'd0, b.gnt});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", {31'd0, VALID}, 32'd0);
        chk("rst_ve", {7'd0, VE}, 32'd0);
        chk("rst_vl", {27'd0, VL}, 32'd0);
        chk("rst_req_ready", {29'd0, REQ_READY}, 32'd0);
        chk("rst_gnt", {29'd0, GNT}, 32'd0);
        chk("rst_eos_done", {31'd0, EOS_DONE}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // all three requesters at once from ptr 0, then req0+req2 across the wrap
        exp_word(25'h11, 5'd4, 3'b001);
        exp_word(25'h22, 5'd4, 3'b010);
        exp_word(25'h33, 5'd8, 3'b100);
        fork
            put(0, 25'h11, 5'd4, 1'b1, v);
            put(1, 25'h22, 5'd4, 1'b1, v);
            put(2, 25'h33, 5'd8, 1'b1, v);
        join
        exp_word(25'h44, 5'd8, 3'b001);
        exp_word(25'h55, 5'd8, 3'b100);
        fork
            put(0, 25'h44, 5'd8, 1'b1, v);
            put(2, 25'h55, 5'd8, 1'b1, v);
        join

        // single req0 burst; grant appears one cycle after REQ_VALID
        exp_word(25'd56789, 5'd25, 3'b001);
        exp_word(25'd5, 5'd3, 3'b001);
        fork
            put(0, 25'd56789, 5'd25, 1'b0, v);
            begin
                @(negedge CLK);
                chk("gnt_before_arb", {29'd0, GNT}, 32'd0);
                @(negedge CLK);
                chk("gnt_after_arb", {29'd0, GNT}, 32'd1);
            end
        join
        put(0, 25'd5, 5'd3, 1'b1, v);
        @(negedge CLK);
        chk("gnt_released", {29'd0, GNT}, 32'd0);
        @(posedge CLK);
        #1;

        // bitpos 4: stop bit then 3 pad bits
        eos();

        // bitpos 7: stop bit alone aligns
        exp_word(25'h7F, 5'd7, 3'b010);
        put(1, 25'h7F, 5'd7, 1'b1, v);
        eos();

        // packer stall in the middle of a burst
        exp_word(25'hABC, 5'd12, 3'b100);
        exp_word(25'h1234, 5'd9, 3'b100);
        put(2, 25'hABC, 5'd12, 1'b0, v);
        READY = 1'b0;
        fork
            put(2, 25'h1234, 5'd9, 1'b1, v);
            begin
                hold_chk("grant_stall", 25'h1234, 5'd9);
                @(posedge CLK);
                #1;
                READY = 1'b1;
            end
        join

        // packer stall on stop bit and pad (bitpos 5 -> pad 2)
        READY = 1'b0;
        fork
            eos();
            begin
                cnt = 0;
                while (!VALID && cnt < 20) begin
                    @(negedge CLK);
                    cnt++;
                end
                hold_chk("stop_stall", 25'd1, 5'd1);
                @(posedge CLK);
                #1;
                READY = 1'b1;
                @(posedge CLK);
                #1;
                READY = 1'b0;
                hold_chk("pad_stall", 25'd0, 5'd2);
                @(posedge CLK);
                #1;
                READY = 1'b1;
            end
        join

        // zero-length word is consumed without a packer beat, LAST still ends the burst
        exp_word(25'd3, 5'd3, 3'b001);
        exp_word(25'h99, 5'd0, 3'b001);
        put(0, 25'd3, 5'd3, 1'b0, v);
        put(0, 25'h99, 5'd0, 1'b1, v);
        chk("vl0_not_forwarded", {31'd0, v}, 32'd0);
        @(negedge CLK);
        chk("vl0_last_release", {29'd0, GNT}, 32'd0);
        @(posedge CLK);
        #1;

        // oversize length is forwarded and latches ERR
        exp_word(25'h1ABCDEF, 5'd31, 3'b010);
        put(1, 25'h1ABCDEF, 5'd31, 1'b1, v);
        @(negedge CLK);
        chk("err_set", {31'd0, ERR}, 32'd1);
        @(posedge CLK);
        #1;
        exp_word(25'd1, 5'd1, 3'b100);
        put(2, 25'd1, 5'd1, 1'b1, v);
        exp_word(25'd2, 5'd2, 3'b001);
        put(0, 25'd2, 5'd2, 1'b1, v);
        @(negedge CLK);
        chk("err_sticky", {31'd0, ERR}, 32'd1);
        @(posedge CLK);
        #1;

        // reset in the middle of a req1 burst with ptr at 1
        exp_word(25'd6, 5'd3, 3'b010);
        put(1, 25'd6, 5'd3, 1'b0, v);
        REQ_VE[25 +: 25] = 25'd7;
        REQ_VL[5 +: 5]   = 5'd4;
        REQ_LAST[1]      = 1'b0;
        REQ_VALID[1]     = 1'b1;
        READY            = 1'b0;
        RST              = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("midrst_valid", {31'd0, VALID}, 32'd0);
        chk("midrst_gnt", {29'd0, GNT}, 32'd0);
        chk("midrst_req_ready", {29'd0, REQ_READY}, 32'd0);
        chk("midrst_err", {31'd0, ERR}, 32'd0);
        chk("midrst_eos_done", {31'd0, EOS_DONE}, 32'd0);
        @(posedge CLK);
        #1;
        REQ_VALID = 3'b000;
        RST       = 1'b0;
        READY     = 1'b1;
        mbit      = 0;

        // ptr back at 0 and bitpos cleared: req0 wins, then pad after 11 bits is 4
        exp_word(25'h10, 5'd5, 3'b001);
        exp_word(25'h20, 5'd6, 3'b010);
        fork
            put(0, 25'h10, 5'd5, 1'b1, v);
            put(1, 25'h20, 5'd6, 1'b1, v);
        join
        eos();

        cnt = 0;
        while (exp_q.size() != 0 && cnt < 20) begin
            @(negedge CLK);
            cnt++;
        end
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
